// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the clock period meter.
// PERIOD_AVG_EN selects 4-period averaging in clock_period_meter.
package clock_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_t;

   localparam int CNT_W_DEF = 16;
   localparam int AVG_DEPTH = 4;
   localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input plus
// single-cycle rise/fall pulse generation on the synchronized level.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic nrst,
   input  logic i_sig,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_level;

   assign w_level = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
         r_prev <= w_level;
      end
   end

   assign o_level = w_level;
   assign o_rise  = w_level & ~r_prev;
   assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous divided clock.
// Define PERIOD_AVG_EN to report the floor-average of 4 periods.
module clock_period_meter
   import clock_meter_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             nrst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_MAX = '1;

   state_t           r_state;
   logic [CNT_W-1:0] r_pcnt;
   logic [CNT_W-1:0] r_hcnt;
   logic             r_hdone;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high;
   logic             r_valid;
   logic             r_timeout;
   logic             w_level;
   logic             w_rise;
   logic             w_fall;

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_edge_sync (
      .clk_in (clk_in),
      .nrst   (nrst),
      .i_sig  (sig_in),
      .o_level(w_level),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

`ifdef PERIOD_AVG_EN
   localparam logic [AVG_SHIFT-1:0] C_NLAST =
      AVG_SHIFT'(AVG_DEPTH - 1);

   logic [CNT_W+1:0]     r_acc_p;
   logic [CNT_W+1:0]     r_acc_h;
   logic [AVG_SHIFT-1:0] r_nsamp;
   logic [CNT_W+1:0]     w_sum_p;
   logic [CNT_W+1:0]     w_sum_h;
   logic [CNT_W+1:0]     w_shr_p;
   logic [CNT_W+1:0]     w_shr_h;

   assign w_sum_p = r_acc_p + (CNT_W+2)'(r_pcnt);
   assign w_sum_h = r_acc_h + (CNT_W+2)'(r_hcnt);
   assign w_shr_p = w_sum_p >> AVG_SHIFT;
   assign w_shr_h = w_sum_h >> AVG_SHIFT;
`endif

   // A rising edge both reports and restarts: counters load 1 so
   // the edge cycle itself belongs to the next period.
   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         r_state   <= ST_IDLE;
         r_pcnt    <= '0;
         r_hcnt    <= '0;
         r_hdone   <= 1'b0;
         r_period  <= '0;
         r_high    <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
`ifdef PERIOD_AVG_EN
         r_acc_p   <= '0;
         r_acc_h   <= '0;
         r_nsamp   <= '0;
`endif
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_state <= ST_MEASURE;
                  r_pcnt  <= C_ONE;
                  r_hcnt  <= C_ONE;
                  r_hdone <= 1'b0;
               end
            end
            ST_MEASURE: begin
               if (w_rise) begin
`ifdef PERIOD_AVG_EN
                  if (r_nsamp == C_NLAST) begin
                     r_period <= w_shr_p[CNT_W-1:0];
                     r_high   <= w_shr_h[CNT_W-1:0];
                     r_valid  <= 1'b1;
                     r_acc_p  <= '0;
                     r_acc_h  <= '0;
                     r_nsamp  <= '0;
                  end else begin
                     r_acc_p <= w_sum_p;
                     r_acc_h <= w_sum_h;
                     r_nsamp <= r_nsamp + AVG_SHIFT'(1);
                  end
`else
                  r_period <= r_pcnt;
                  r_high   <= r_hcnt;
                  r_valid  <= 1'b1;
`endif
                  r_pcnt  <= C_ONE;
                  r_hcnt  <= C_ONE;
                  r_hdone <= 1'b0;
               end else if (r_pcnt == C_MAX) begin
                  r_state   <= ST_TIMEOUT;
                  r_timeout <= 1'b1;
`ifdef PERIOD_AVG_EN
                  r_acc_p   <= '0;
                  r_acc_h   <= '0;
                  r_nsamp   <= '0;
`endif
               end else begin
                  r_pcnt <= r_pcnt + C_ONE;
                  if (w_fall) begin
                     r_hdone <= 1'b1;
                  end else if (w_level && !r_hdone &&
                               r_hcnt != C_MAX) begin
                     r_hcnt <= r_hcnt + C_ONE;
                  end
               end
            end
            ST_TIMEOUT: begin
               if (w_rise) begin
                  r_state   <= ST_MEASURE;
                  r_timeout <= 1'b0;
                  r_pcnt    <= C_ONE;
                  r_hcnt    <= C_ONE;
                  r_hdone   <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign period    = r_period;
   assign high_time = r_high;
   assign valid     = r_valid;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter (CNT_W=8).
// Builds with or without PERIOD_AVG_EN.
module tb_clock_period_meter;

   localparam int W   = 8;
   localparam int MAXC = 255;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         sig = 1'b0;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         valid;
   logic         timeout;

   clock_period_meter #(
      .CNT_W(W),
      .SYNC_STAGES(2)
   ) dut (
      .clk_in   (clk),
      .nrst     (nrst),
      .sig_in   (sig),
      .period   (period),
      .high_time(high_time),
      .valid    (valid),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p;
      int h;
      int gap;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_err = 0;
   int   n_chk = 0;
   int   cyc = 0;
   int   last_v = 0;

   int   m_state = 0;
   int   m_last = 0;
   int   m_high = 0;
   bit   m_prev_valid = 0;
   int   acc_p = 0;
   int   acc_h = 0;
   int   acc_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      acc_p = 0;
      acc_h = 0;
      acc_n = 0;
   endtask

   // Reference behaviour of one rising edge of the stimulus.
   task automatic model_rise(int high);
      int gap;
      gap = cyc - m_last;
      if (m_state == 1 && gap > MAXC) begin
         m_state = 2;
         model_clear();
      end
      if (m_state == 1) begin
`ifdef PERIOD_AVG_EN
         acc_p += gap;
         acc_h += m_high;
         acc_n++;
         if (acc_n == 4) begin
            q.push_back('{acc_p >> 2, acc_h >> 2, 0});
            model_clear();
         end
`else
         q.push_back('{gap, m_high, m_prev_valid ? gap : 0});
         m_prev_valid = 1;
`endif
      end else begin
         m_state = 1;
         m_prev_valid = 0;
      end
      m_last = cyc;
      m_high = high;
   endtask

   task automatic pulse(int high, int low);
      model_rise(high);
      sig = 1'b1;
      repeat (high) @(negedge clk);
      sig = 1'b0;
      repeat (low) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (nrst && valid) begin
         if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_valid: period=%0d high=%0d, expected no valid",
                     period, high_time);
         end else begin
            mon_e = q.pop_front();
            chk("period", int'(period), mon_e.p);
            chk("high_time", int'(high_time), mon_e.h);
            if (mon_e.gap != 0)
               chk("valid_gap", cyc - last_v, mon_e.gap);
         end
         last_v = cyc;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_period", int'(period), 0);
      chk("rst_high", int'(high_time), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_timeout", int'(timeout), 0);
      nrst = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 6; i++) pulse(5, 5);
      for (int i = 0; i < 6; i++) pulse(2, 5);
      for (int i = 0; i < 100; i++) pulse(1, 3);

      repeat (190) @(negedge clk);
      chk("pre_to_timeout", int'(timeout), 0);
      repeat (100) @(negedge clk);
      chk("timeout_set", int'(timeout), 1);
`ifndef PERIOD_AVG_EN
      chk("to_hold_period", int'(period), 4);
      chk("to_hold_high", int'(high_time), 1);
`endif
      pulse(5, 5);
      chk("timeout_clear", int'(timeout), 0);
      pulse(5, 5);
      pulse(5, 5);

      for (int i = 0; i < 3; i++) pulse(6, 6);
      model_rise(6);
      sig = 1'b1;
      repeat (6) @(negedge clk);
      sig = 1'b0;
      chk("pre_rst_queue", q.size(), 0);
      #2 nrst = 1'b0;
      #1;
      chk("mid_rst_period", int'(period), 0);
      chk("mid_rst_high", int'(high_time), 0);
      chk("mid_rst_valid", int'(valid), 0);
      chk("mid_rst_timeout", int'(timeout), 0);
      m_state = 0;
      model_clear();
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) pulse(6, 6);

      pulse(5, 5);
      pulse(5, 6);
      pulse(5, 5);
      pulse(5, 6);
      pulse(5, 5);
      repeat (20) @(negedge clk);
      chk("leftover_expected", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
